// File: rtl/uart_pkg.sv
// Shared types, defaults and divider arithmetic for the arbitrated UART transmitter.
package uart_pkg;

  localparam int DEF_CLK_FREQ          = 125_000_000;
  localparam int DEF_BAUD_RATE         = 9600;
  localparam int DEF_OVERSAMPLING_RATE = 16;
  localparam int DEF_N_REQ             = 4;
  localparam int TICKS_PER_BIT         = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  typedef struct packed {
    tx_state_t   state;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  data;
    logic        txd;
  } tx_regs_t;

  localparam tx_regs_t TX_REGS_RST = '{
    state:    S_IDLE,
    tick_cnt: 4'd0,
    bit_cnt:  3'd0,
    data:     8'd0,
    txd:      1'b1
  };

  function automatic int max_cnt(input int clk_freq, input int baud_rate, input int os_rate);
    return clk_freq / baud_rate / os_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversampling tick divider: one-CLK tick every MAX_CNT cycles.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int MAX_CNT = max_cnt(DEF_CLK_FREQ, DEF_BAUD_RATE, DEF_OVERSAMPLING_RATE)
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int CW = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(MAX_CNT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single 8-data/even-XOR-parity/1-stop UART transmitter.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ          = DEF_CLK_FREQ,
  parameter int BAUD_RATE         = DEF_BAUD_RATE,
  parameter int OVERSAMPLING_RATE = DEF_OVERSAMPLING_RATE,
  parameter int N_REQ             = DEF_N_REQ
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [8*N_REQ-1:0] DATA,
  output logic [N_REQ-1:0]   GNT,
  output logic [2:0]         CUR_ID,
  output logic               BUSY,
  output logic               TXD
);

  localparam int MAX_CNT = max_cnt(CLK_FREQ, BAUD_RATE, OVERSAMPLING_RATE);
  localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic                      tick;
  logic [N_REQ-1:0][7:0]     data_arr;
  logic [IW-1:0]             sel;
  logic [IW-1:0]             last, last_n;
  logic [N_REQ-1:0]          gnt, gnt_n;
  logic [2:0]                cur_id, cur_id_n;
  tx_regs_t                  r, r_n;
  logic                      bit_end;
  logic [2:0]                next_bit;

  uart_baud_gen #(.MAX_CNT(MAX_CNT)) u_baud (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  assign data_arr = DATA;

  // Scan downward so the nearest requester after 'from' is the last one to win.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [IW-1:0] from);
    logic [IW-1:0] pick;
    logic [IW-1:0] j;
    pick = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = IW'((int'(from) + k) % N_REQ);
      if (req[j]) pick = j;
    end
    return pick;
  endfunction

  assign sel      = rr_pick(REQ, last);
  assign bit_end  = tick && (r.tick_cnt == 4'(TICKS_PER_BIT - 1));
  assign next_bit = r.bit_cnt + 3'd1;

  always_comb begin
    r_n      = r;
    gnt_n    = '0;
    cur_id_n = cur_id;
    last_n   = last;
    case (r.state)
      S_IDLE: begin
        // tick_cnt restarts here, so the start bit is short by the divider phase.
        if (|REQ) begin
          r_n.state    = S_START;
          r_n.data     = data_arr[sel];
          r_n.txd      = 1'b0;
          r_n.tick_cnt = '0;
          r_n.bit_cnt  = '0;
          gnt_n[sel]   = 1'b1;
          cur_id_n     = 3'(sel);
          last_n       = sel;
        end
      end
      S_START, S_DATA, S_PARITY, S_STOP: begin
        if (tick) r_n.tick_cnt = r.tick_cnt + 4'd1;
        if (bit_end) begin
          r_n.tick_cnt = '0;
          case (r.state)
            S_START: begin
              r_n.state   = S_DATA;
              r_n.bit_cnt = '0;
              r_n.txd     = r.data[0];
            end
            S_DATA: begin
              if (r.bit_cnt == 3'd7) begin
                r_n.state = S_PARITY;
                r_n.txd   = ^r.data;
              end else begin
                r_n.bit_cnt = next_bit;
                r_n.txd     = r.data[next_bit];
              end
            end
            S_PARITY: begin
              r_n.state = S_STOP;
              r_n.txd   = 1'b1;
            end
            default: begin
              r_n.state = S_IDLE;
              r_n.txd   = 1'b1;
            end
          endcase
        end
      end
      default: r_n = TX_REGS_RST;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r      <= TX_REGS_RST;
      gnt    <= '0;
      cur_id <= '0;
      last   <= IW'(N_REQ - 1);
    end else begin
      r      <= r_n;
      gnt    <= gnt_n;
      cur_id <= cur_id_n;
      last   <= last_n;
    end
  end

  assign GNT    = gnt;
  assign CUR_ID = cur_id;
  assign BUSY   = (r.state != S_IDLE);
  assign TXD    = r.txd;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected frames, a monitor decodes GNT/TXD and compares.
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int BIT_CLK = 160;
  localparam int FRAME   = 10 * BIT_CLK;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ;
  logic [8*N-1:0] DATA;
  logic [N-1:0]   GNT;
  logic [2:0]     CUR_ID;
  logic           BUSY;
  logic           TXD;

  uart_tx_arbiter #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLING_RATE(16), .N_REQ(N)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DATA(DATA),
    .GNT(GNT), .CUR_ID(CUR_ID), .BUSY(BUSY), .TXD(TXD)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         id;
    logic [7:0] dat;
    logic       par;
    bit         gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0, errors = 0, n_gnt = 0;
  int   cyc = 0, end_cyc = 0, idx = 0;
  bit   inflight = 0;
  logic line [0:2047];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d, input logic p, input bit g);
    exp_t e;
    e.id = id; e.dat = d; e.par = p; e.gap = g;
    exp_q.push_back(e);
  endtask

  task automatic close_frame();
    int   len, s, bad, k;
    logic e;
    len = idx;
    s   = len - FRAME;
    checks++;
    if (s < 151 || s > 160) begin
      errors++;
      $display("FAIL start_len id%0d actual=%0d required=151..160", cur.id, s);
    end
    bad = -1;
    if (len >= FRAME && len <= 2048) begin
      for (int j = 0; j < len; j++) begin
        if (j < s) e = 1'b0;
        else begin
          k = (j - s) / BIT_CLK;
          e = (k < 8) ? cur.dat[k] : (k == 8) ? cur.par : 1'b1;
        end
        if (line[j] !== e && bad < 0) bad = j;
      end
    end
    chk($sformatf("frame_bits id%0d first_bad_sample", cur.id), bad, -1);
  endtask

  task automatic monitor();
    forever begin
      @(negedge CLK);
      cyc++;
      if (RST) inflight = 0;
      else begin
        if (inflight && !BUSY) begin
          close_frame();
          inflight = 0;
          end_cyc  = cyc;
        end
        if (GNT != '0) begin
          n_gnt++;
          chk("gnt_onehot", $countones(GNT), 1);
          chk("gnt_while_busy", inflight, 0);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_gnt actual=%b required=none", GNT);
          end else begin
            cur = exp_q.pop_front();
            chk("gnt_id", GNT, 32'd1 << cur.id);
            chk("cur_id", CUR_ID, cur.id);
            if (cur.gap) begin
              checks++;
              if (cyc - end_cyc > 2) begin
                errors++;
                $display("FAIL b2b_gap actual=%0d required<=2", cyc - end_cyc);
              end
            end
            inflight = 1;
            idx      = 0;
          end
        end
        if (inflight) begin
          if (idx < 2048) line[idx] = TXD;
          idx++;
        end
      end
    end
  endtask

  task automatic wait_gnt(input logic [N-1:0] mask, input string name);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((GNT & mask) == '0 && n < 2000);
    if ((GNT & mask) == '0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_gnt required=gnt", name);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || inflight || BUSY) && n < budget) begin
      @(posedge CLK);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
    repeat (5) @(posedge CLK);
  endtask

  task automatic send(input int id, input logic [7:0] d, input logic p);
    push(id, d, p, 0);
    @(negedge CLK);
    DATA[8*id +: 8] = d;
    REQ[id] = 1'b1;
    wait_gnt(N'(1) << id, "send");
    REQ[id] = 1'b0;
  endtask

  initial begin
    RST = 1'b1; REQ = '0; DATA = '0;
    fork monitor(); join_none
    repeat (3) @(negedge CLK);
    chk("rst_txd", TXD, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_gnt", GNT, 0);
    chk("rst_cur_id", CUR_ID, 0);
    RST = 1'b0;

    // Fairness: all four held, round robin from 0 after reset.
    push(0, 8'h10, 1, 0); push(1, 8'h21, 0, 1); push(2, 8'h32, 1, 1);
    push(3, 8'h43, 1, 1); push(0, 8'h10, 1, 1);
    @(negedge CLK);
    DATA = {8'h43, 8'h32, 8'h21, 8'h10};
    REQ  = 4'b1111;
    for (int g = 0; g < 5; g++) wait_gnt(4'b1111, "fair");
    REQ = '0;
    wait_done(4000);
    chk("gnt_count_fair", n_gnt, 5);

    // Single frame with a one-cycle withdrawn request mid-frame.
    push(2, 8'h41, 0, 0);
    @(negedge CLK);
    DATA[23:16] = 8'h41;
    REQ = 4'b0100;
    @(negedge CLK);
    chk("gnt_latency", GNT, 4'b0100);
    REQ = '0;
    repeat (300) @(negedge CLK);
    DATA[15:8] = 8'h55;
    REQ[1] = 1'b1;
    @(negedge CLK);
    REQ[1] = 1'b0;
    wait_done(4000);
    chk("gnt_count_withdraw", n_gnt, 6);
    repeat (20) @(negedge CLK);
    chk("cur_id_hold", CUR_ID, 2);
    chk("idle_txd", TXD, 1);

    // Parity corners.
    send(0, 8'hFF, 1'b0);
    send(3, 8'h07, 1'b1);
    wait_done(5000);
    chk("gnt_count_parity", n_gnt, 8);

    // Back-to-back frames from a continuously held request.
    push(3, 8'hA5, 0, 0); push(3, 8'hA5, 0, 1);
    @(negedge CLK);
    DATA[31:24] = 8'hA5;
    REQ = 4'b1000;
    wait_gnt(4'b1000, "b2b");
    wait_gnt(4'b1000, "b2b");
    REQ = '0;
    wait_done(4000);
    chk("gnt_count_b2b", n_gnt, 10);

    // Reset during data bit 3, then requesters 0 and 3 pending.
    send(2, 8'h96, 1'b0);
    repeat (700) @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    chk("midrst_txd", TXD, 1);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_gnt", GNT, 0);
    @(negedge CLK);
    chk("midrst_cur_id", CUR_ID, 0);
    push(0, 8'h01, 1, 0); push(3, 8'h80, 1, 0);
    DATA = {8'h80, 8'h00, 8'h96, 8'h01};
    REQ  = 4'b1001;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    wait_gnt(4'b0001, "post_rst0");
    REQ[0] = 1'b0;
    wait_gnt(4'b1000, "post_rst3");
    REQ[3] = 1'b0;
    wait_done(5000);
    chk("gnt_count_reset", n_gnt, 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLK_FREQ, default 125_000_000, is the system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, is the line rate in bit/s.
REQ-003 Parameter OVERSAMPLING_RATE, default 16, is the number of baud ticks per bit.
REQ-004 Parameter N_REQ, default 4, is the number of requesters; the supported range is 2 to 8.
REQ-005 Port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port CLK, input, 1 bit: the single clock; all logic runs on rising CLK.
REQ-007 Port REQ, input, N_REQ bits: REQ[i] high means requester i has a byte to send.
REQ-008 Port DATA, input, 8*N_REQ bits: DATA[8i+7:8i] is requester i's byte, held stable while REQ[i] is high.
REQ-009 Port GNT, output, N_REQ bits: one-cycle pulse; GNT[i] means requester i's byte was captured.
REQ-010 Port CUR_ID, output, 3 bits: index of the requester whose frame is on the line.
REQ-011 Port BUSY, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-012 Port TXD, output, 1 bit: serial line, which idles high.

Function
REQ-013 The baud divider SHALL be free-running with MAX_CNT = CLK_FREQ/BAUD_RATE/OVERSAMPLING_RATE, producing a one-CLK tick when the count equals MAX_CNT-1.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-015 In IDLE, if any REQ bit is high, the FSM SHALL register the selected DATA byte, pulse the matching GNT bit, load CUR_ID, and enter START, all on the next CLK edge.
REQ-016 Selection SHALL be round-robin: search from LAST+1 upward, wrapping modulo N_REQ; LAST updates to the granted index.
REQ-017 Each bit SHALL last 16 ticks, counted by a 4-bit tick counter; the state advances on the tick where the count equals 15.
REQ-018 Because the start bit begins unaligned to a tick, it SHALL be up to one tick period short; every other bit SHALL be exactly 16 ticks.
REQ-019 TXD SHALL be registered: 0 in START; data bits LSB first in DATA (3-bit bit counter, exit after bit 7); XOR of the 8 data bits in PARITY; 1 in STOP and IDLE.
REQ-020 On STOP completion the FSM SHALL return to IDLE; a pending REQ is granted on the following edge, giving no back-to-back idle gap beyond 2 CLK.
REQ-021 A REQ[i] dropped before its grant SHALL produce no grant and no frame.
REQ-022 REQ changes during a frame SHALL be ignored until IDLE; at most one GNT bit SHALL be high in any cycle.
REQ-023 CUR_ID SHALL hold its last value while IDLE.

Reset
REQ-024 Asserting RST SHALL immediately force: TXD=1, GNT=0, BUSY=0, CUR_ID=0, state IDLE, LAST=N_REQ-1, and all counters to 0.
REQ-025 Reset mid-frame SHALL abort the frame with no further GNT; after release the aborted requester receives no retry unless it still asserts REQ.

Structure
REQ-026 The state encoding, parameter defaults and the MAX_CNT expression SHALL live in the shared package uart_pkg.
REQ-027 The tick generator SHALL be a sub-module, uart_baud_gen, instantiated once.

Verification
Bench parameters are CLK_FREQ=1_600_000 and BAUD_RATE=10_000, giving MAX_CNT=10, a 160-CLK bit and an 11-bit frame.
REQ-028 Single frame: REQ[2]=1 with DATA=8'h41 -> GNT[2] pulses 1 CLK later, CUR_ID=2, and TXD carries 0,1,0,0,0,0,0,1,0, parity 0, then 1, each bit 160 CLK except a start bit of 151-160 CLK.
REQ-029 Fairness: REQ=4'b1111 held with bytes 8'h10/8'h21/8'h32/8'h43 -> grants in order 0,1,2,3,0, with exactly 4 frames per cycle of grants.
REQ-030 Parity: DATA=8'hFF -> parity bit 0; DATA=8'h07 -> parity bit 1.
REQ-031 Withdraw: REQ[1] pulsed for 1 CLK during a frame and then dropped -> no GNT[1] and no frame for requester 1.
REQ-032 Reset mid-frame: RST asserted during DATA bit 3 -> TXD=1 and BUSY=0 within the same cycle; after release with REQ[0]=1, GNT[0] is issued and requester 0 is served first.
REQ-033 Back-to-back: REQ[3] held continuously -> the start bit of the next frame begins no more than 2 CLK after the previous stop bit ends.
